ula_seq: RTL and testbench

Upstream sequencer for the ula datapath. It collects an operation code and two operand bytes over one 8-bit valid/ready input stream and holds them stable on the ula a/b/op inputs. It waits out the ula's registered-input/registered-output latency, captures s, and returns the result on a valid/ready output stream. One transaction is in flight at a time. The block is the sole driver of ula a, b and op.

---
 rtl/ula_pkg.sv | 25 ++
 rtl/ula_seq_if.sv | 27 ++
 rtl/ula_seq.sv | 117 +++++++++++
 tb/tb_ula_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ula request sequencer: op codes, FSM encoding
// and default parameter values.
package ula_pkg;

   localparam int OPW_DEFAULT   = 3;
   localparam int LAT_DEFAULT   = 2;

   localparam int OP_ADD        = 0;
   localparam int OP_SUB        = 1;
   localparam int OP_LAST_LEGAL = 1;

   typedef enum logic [2:0] {
      S_GET_OP = 3'd0,
      S_GET_A  = 3'd1,
      S_GET_B  = 3'd2,
      S_EXEC   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   // Only the low codes are implemented by the ula; anything above is rejected.
   function automatic logic op_is_legal(input int unsigned op);
      return op <= OP_LAST_LEGAL;
   endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Request/response streams plus the ula operand/result wires of the sequencer.
// The slave view is the sequencer itself; the master view is its environment.
interface ula_seq_if #(
   parameter int OPW = 3
);
   logic [7:0]     in_data;
   logic           in_valid;
   logic           in_ready;
   logic [7:0]     out_data;
   logic           out_err;
   logic           out_valid;
   logic           out_ready;
   logic [7:0]     ula_a;
   logic [7:0]     ula_b;
   logic [OPW-1:0] ula_op;
   logic [7:0]     ula_s;

   modport slave (
      input  in_data, in_valid, out_ready, ula_s,
      output in_ready, out_data, out_err, out_valid, ula_a, ula_b, ula_op
   );

   modport master (
      output in_data, in_valid, out_ready, ula_s,
      input  in_ready, out_data, out_err, out_valid, ula_a, ula_b, ula_op
   );
endinterface

// File: rtl/ula_seq.sv
// Collects op/A/B beats, holds them on the ula inputs, waits out the ula
// pipeline and returns the captured result (or an error) on the output stream.
module ula_seq
   import ula_pkg::*;
#(
   parameter int LAT = LAT_DEFAULT,
   parameter int OPW = OPW_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   ula_seq_if.slave  bus
);

   // a/b/op are registered here, so the ula's own input register samples them
   // one edge after the B beat; waiting LAT+1 edges lands on a settled ula_s.
   localparam logic [3:0] CNT_LOAD = 4'(LAT);

   state_t         state_reg,    state_next;
   logic [3:0]     cnt_reg,      cnt_next;
   logic [7:0]     out_data_reg, out_data_next;
   logic           out_err_reg,  out_err_next;
   logic [7:0]     ula_a_reg,    ula_a_next;
   logic [7:0]     ula_b_reg,    ula_b_next;
   logic [OPW-1:0] ula_op_reg,   ula_op_next;

   logic in_ready_int;
   logic out_valid_int;

   assign in_ready_int  = (state_reg == S_GET_OP) || (state_reg == S_GET_A) ||
                          (state_reg == S_GET_B);
   assign out_valid_int = (state_reg == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_GET_OP;
         cnt_reg      <= '0;
         out_data_reg <= '0;
         out_err_reg  <= 1'b0;
         ula_a_reg    <= '0;
         ula_b_reg    <= '0;
         ula_op_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         out_data_reg <= out_data_next;
         out_err_reg  <= out_err_next;
         ula_a_reg    <= ula_a_next;
         ula_b_reg    <= ula_b_next;
         ula_op_reg   <= ula_op_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      out_data_next = out_data_reg;
      out_err_next  = out_err_reg;
      ula_a_next    = ula_a_reg;
      ula_b_next    = ula_b_reg;
      ula_op_next   = ula_op_reg;

      case (state_reg)
         S_GET_OP: begin
            if (bus.in_valid) begin
               ula_op_next = bus.in_data[OPW-1:0];
               state_next  = S_GET_A;
            end
         end
         S_GET_A: begin
            if (bus.in_valid) begin
               ula_a_next = bus.in_data;
               state_next = S_GET_B;
            end
         end
         S_GET_B: begin
            if (bus.in_valid) begin
               ula_b_next = bus.in_data;
               if (op_is_legal(32'(ula_op_reg))) begin
                  cnt_next   = CNT_LOAD;
                  state_next = S_EXEC;
               end else begin
                  // Illegal ops never reach EXEC, so the ula is never asked to run them.
                  out_data_next = 8'h00;
                  out_err_next  = 1'b1;
                  state_next    = S_RESP;
               end
            end
         end
         S_EXEC: begin
            if (cnt_reg == 4'd0) begin
               out_data_next = bus.ula_s;
               out_err_next  = 1'b0;
               state_next    = S_RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.out_ready) begin
               state_next = S_GET_OP;
            end
         end
         default: begin
            state_next = S_GET_OP;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = out_data_reg;
   assign bus.out_err   = out_err_reg;
   assign bus.ula_a     = ula_a_reg;
   assign bus.ula_b     = ula_b_reg;
   assign bus.ula_op    = ula_op_reg;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: a two-stage ula model closes the loop, a vector
// table covers arithmetic/latency/back-pressure, hand sequences cover reset.
module tb_ula_seq;

   localparam int LAT = 2;
   localparam int OPW = 3;
   localparam int NV  = 8;

   logic clk;
   logic rst;

   ula_seq_if #(.OPW(OPW)) bus ();

   ula_seq #(.LAT(LAT), .OPW(OPW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ula model: registered inputs, registered output (two edges of latency).
   logic [7:0] a_r, b_r, s_r;
   logic [2:0] op_r;
   always_ff @(posedge clk) begin
      a_r  <= bus.ula_a;
      b_r  <= bus.ula_b;
      op_r <= bus.ula_op;
      case (op_r)
         3'd0:    s_r <= a_r + b_r;
         3'd1:    s_r <= a_r - b_r;
         default: s_r <= 8'h00;
      endcase
   end
   assign bus.ula_s = s_r;

   typedef struct {
      logic [7:0] op_byte;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_data;
      logic       exp_err;
      logic       chain;
      int         hold;
   } vec_t;

   vec_t vecs[NV];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present a beat and return just after the edge on which it transferred.
   task automatic send_beat(input logic [7:0] d);
      int n;
      n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("beat_accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input int i);
      vec_t v;
      int lat;
      int exp_lat;
      v = vecs[i];
      send_beat(v.op_byte);
      send_beat(v.a);
      send_beat(v.b);
      if (v.chain && i + 1 < NV) bus.in_data = vecs[i + 1].op_byte;
      else                       bus.in_valid = 1'b0;
      bus.out_ready = (v.hold == 0);
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 40) begin
         check("exec_ula_a",    32'(bus.ula_a),    32'(v.a));
         check("exec_ula_b",    32'(bus.ula_b),    32'(v.b));
         check("exec_ula_op",   32'(bus.ula_op),   32'(v.op_byte[2:0]));
         check("exec_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      exp_lat = v.exp_err ? 0 : LAT + 1;
      check("latency",       32'(lat),          32'(exp_lat));
      check("out_data",      32'(bus.out_data), 32'(v.exp_data));
      check("out_err",       32'(bus.out_err),  32'(v.exp_err));
      check("resp_ula_op",   32'(bus.ula_op),   32'(v.op_byte[2:0]));
      check("resp_ula_a",    32'(bus.ula_a),    32'(v.a));
      check("resp_ula_b",    32'(bus.ula_b),    32'(v.b));
      check("resp_in_ready", 32'(bus.in_ready), 32'd0);
      $display("req %0d: op=0x%02h a=0x%02h b=0x%02h -> data=0x%02h err=%0b lat=%0d",
               i, v.op_byte, v.a, v.b, bus.out_data, bus.out_err, lat);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_out_data",  32'(bus.out_data),  32'(v.exp_data));
         check("hold_out_err",   32'(bus.out_err),   32'(v.exp_err));
         check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_xfer_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_xfer_in_ready",  32'(bus.in_ready),  32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
      check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      check({tag, "_ula_a"},     32'(bus.ula_a),     32'd0);
      check({tag, "_ula_b"},     32'(bus.ula_b),     32'd0);
      check({tag, "_ula_op"},    32'(bus.ula_op),    32'd0);
   endtask

   initial begin
      //          op      A      B      data   err   chain hold
      vecs[0] = '{8'h00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0};
      vecs[1] = '{8'h01, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 0};
      vecs[2] = '{8'h00, 8'hC8, 8'h64, 8'h2C, 1'b0, 1'b1, 0};
      vecs[3] = '{8'h01, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0};
      vecs[4] = '{8'h00, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 5};
      vecs[5] = '{8'h05, 8'h11, 8'h22, 8'h00, 1'b1, 1'b0, 0};
      vecs[6] = '{8'h01, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 0};
      vecs[7] = '{8'hF8, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 0};

      rst           = 1'b1;
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      for (int i = 0; i < NV; i++) run_req(i);

      // Reset while EXEC is counting: the pending result must vanish.
      send_beat(8'h00);
      send_beat(8'h44);
      send_beat(8'h55);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_exec_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check_reset_state("rst_exec");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         check("rst_exec_no_result", 32'(bus.out_valid), 32'd0);
      end
      $display("req rst_exec: reset during EXEC, out_valid=%0b", bus.out_valid);

      // Reset with a partial request sitting in GET_B.
      send_beat(8'h01);
      send_beat(8'h33);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_getb_in_ready", 32'(bus.in_ready), 32'd1);
      check("pre_rst_getb_ula_a",    32'(bus.ula_a),    32'h33);
      rst = 1'b1;
      #1;
      check_reset_state("rst_getb");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_getb_no_result", 32'(bus.out_valid), 32'd0);
      $display("req rst_getb: reset during GET_B, out_valid=%0b", bus.out_valid);

      run_req(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
